pool_bank_sched: RTL and testbench

Ping-pong scheduler for the pooled feature-map buffer. Owns two single-port RAM banks.
- The pooling engine's read-modify-write port is steered to the bank currently being filled.
- The next-layer loader reads the other, completed bank through a req/gnt/valid handshake.
- Tracks per-bank ownership, so pooling of frame-set N+1 overlaps consumption of frame-set N.

---
 rtl/pool_bank_sched.sv | 195 +++++++++++++++++++
 tb/tb_pool_bank_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_bank_sched.sv
// rtl/pool_bank_sched.sv - ping-pong bank scheduler for the pooled feature-map buffer
// Optional feature macro: POOL_BANK_SCRUB_EN (zero-fills a bank after the loader releases it)
module pool_bank_sched #(
    parameter int DATA_WIDTH      = 16,
    parameter int POOL_ADDR_WIDTH = 10,
    parameter int FRAME_WORDS     = 784
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pool_done,
    input  logic                       pool_wren,
    input  logic                       pool_rden,
    input  logic [POOL_ADDR_WIDTH-1:0] pool_addr,
    input  logic [DATA_WIDTH-1:0]      pool_wdata,
    output logic [DATA_WIDTH-1:0]      pool_q,
    output logic                       pool_ready,
    input  logic                       rd_req,
    input  logic [POOL_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_gnt,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_data,
    input  logic                       rd_frame_done,
    output logic                       rd_frame_avail,
    output logic                       err_overrun,
    output logic [POOL_ADDR_WIDTH-1:0] bank0_addr,
    output logic [DATA_WIDTH-1:0]      bank0_wdata,
    output logic                       bank0_wren,
    output logic                       bank0_rden,
    input  logic [DATA_WIDTH-1:0]      bank0_q,
    output logic [POOL_ADDR_WIDTH-1:0] bank1_addr,
    output logic [DATA_WIDTH-1:0]      bank1_wdata,
    output logic                       bank1_wren,
    output logic                       bank1_rden,
    input  logic [DATA_WIDTH-1:0]      bank1_q
);

    // A frame set must fit in one bank.
    if (FRAME_WORDS > (1 << POOL_ADDR_WIDTH)) begin : g_frame_words_check
        $error("FRAME_WORDS exceeds bank depth");
    end

`ifdef POOL_BANK_SCRUB_EN
    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_FILL  = 3'd1,
        ST_FULL  = 3'd2,
        ST_READ  = 3'd3,
        ST_SCRUB = 3'd4
    } bank_state_t;

    localparam logic [POOL_ADDR_WIDTH-1:0] SCRUB_LAST = POOL_ADDR_WIDTH'(FRAME_WORDS - 1);

    logic [POOL_ADDR_WIDTH-1:0] scrub_cnt_q [2];
`else
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2,
        ST_READ  = 2'd3
    } bank_state_t;
`endif

    bank_state_t state_q [2];
    bank_state_t state_d [2];

    logic wr_bank, rd_bank;
    logic wr_bank_d, rd_bank_d;
    logic eng_req, eng_ok, done_ok, rfd_ok, err_event;

    logic [POOL_ADDR_WIDTH-1:0] b_addr  [2];
    logic [DATA_WIDTH-1:0]      b_wdata [2];
    logic                       b_wren  [2];
    logic                       b_rden  [2];

    // Side availability, grant and accepted/ignored event decode.
    always_comb begin
        pool_ready     = (state_q[wr_bank] == ST_EMPTY) || (state_q[wr_bank] == ST_FILL);
        rd_frame_avail = (state_q[rd_bank] == ST_FULL)  || (state_q[rd_bank] == ST_READ);
        rd_gnt         = rd_req & rd_frame_avail;
        eng_req        = pool_wren | pool_rden;
        eng_ok         = eng_req & pool_ready;
        done_ok        = pool_done & pool_ready;
        rfd_ok         = rd_frame_done & rd_frame_avail;
        err_event      = ((pool_done | eng_req) & ~pool_ready) | (rd_frame_done & ~rd_frame_avail);
    end

    // Per-bank next state; engine and loader never own the same bank in the same state.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (wr_bank == 1'(b)) begin
                if (done_ok)
                    state_d[b] = ST_FULL;
                else if (eng_ok && state_q[b] == ST_EMPTY)
                    state_d[b] = ST_FILL;
            end
            if (rd_bank == 1'(b)) begin
                if (rfd_ok)
`ifdef POOL_BANK_SCRUB_EN
                    state_d[b] = ST_SCRUB;
`else
                    state_d[b] = ST_EMPTY;
`endif
                else if (rd_gnt && state_q[b] == ST_FULL)
                    state_d[b] = ST_READ;
            end
`ifdef POOL_BANK_SCRUB_EN
            if (state_q[b] == ST_SCRUB && scrub_cnt_q[b] == SCRUB_LAST)
                state_d[b] = ST_EMPTY;
`endif
        end
    end

    // Bank port steering: scrub, then engine on wr_bank, then loader on rd_bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            b_addr[b]  = '0;
            b_wdata[b] = '0;
            b_wren[b]  = 1'b0;
            b_rden[b]  = 1'b0;
`ifdef POOL_BANK_SCRUB_EN
            if (state_q[b] == ST_SCRUB) begin
                b_wren[b] = 1'b1;
                b_addr[b] = scrub_cnt_q[b];
            end else
`endif
            if (wr_bank == 1'(b) && eng_ok) begin
                b_wren[b]  = pool_wren;
                b_rden[b]  = pool_rden;
                b_addr[b]  = pool_addr;
                b_wdata[b] = pool_wren ? pool_wdata : '0;
            end else if (rd_bank == 1'(b) && rd_gnt) begin
                b_rden[b] = 1'b1;
                b_addr[b] = rd_addr;
            end
        end
    end

    assign bank0_addr  = b_addr[0];
    assign bank0_wdata = b_wdata[0];
    assign bank0_wren  = b_wren[0];
    assign bank0_rden  = b_rden[0];
    assign bank1_addr  = b_addr[1];
    assign bank1_wdata = b_wdata[1];
    assign bank1_wren  = b_wren[1];
    assign bank1_rden  = b_rden[1];

    // Read data follows the bank selected when the read was issued.
    assign pool_q  = wr_bank_d ? bank1_q : bank0_q;
    assign rd_data = rd_bank_d ? bank1_q : bank0_q;

    // Bank states, side selects, delayed selects, grant pipeline and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                state_q[b] <= ST_EMPTY;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_bank_d   <= 1'b0;
            rd_bank_d   <= 1'b0;
            rd_valid    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++)
                state_q[b] <= state_d[b];
            if (done_ok)
                wr_bank <= ~wr_bank;
            if (rfd_ok)
                rd_bank <= ~rd_bank;
            wr_bank_d <= wr_bank;
            rd_bank_d <= rd_bank;
            rd_valid  <= rd_gnt;
            if (err_event)
                err_overrun <= 1'b1;
        end
    end

`ifdef POOL_BANK_SCRUB_EN
    // Scrub address counters, one per bank, running only while that bank scrubs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                scrub_cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (state_q[b] == ST_SCRUB && scrub_cnt_q[b] != SCRUB_LAST)
                    scrub_cnt_q[b] <= scrub_cnt_q[b] + 1'b1;
                else
                    scrub_cnt_q[b] <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pool_bank_sched.sv
// tb/tb_pool_bank_sched.sv - directed vector bench for pool_bank_sched
module tb_pool_bank_sched;

`ifdef POOL_BANK_SCRUB_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pool_done, pool_wren, pool_rden;
    logic [9:0]  pool_addr;
    logic [15:0] pool_wdata, pool_q;
    logic        pool_ready;
    logic        rd_req, rd_gnt, rd_valid, rd_frame_done, rd_frame_avail, err_overrun;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic [9:0]  bank0_addr, bank1_addr;
    logic [15:0] bank0_wdata, bank1_wdata, bank0_q, bank1_q;
    logic        bank0_wren, bank0_rden, bank1_wren, bank1_rden;

    logic [15:0] mem0 [1024];
    logic [15:0] mem1 [1024];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pool_bank_sched #(.DATA_WIDTH(16), .POOL_ADDR_WIDTH(10), .FRAME_WORDS(16)) dut (
        .clk(clk), .reset(reset),
        .pool_done(pool_done), .pool_wren(pool_wren), .pool_rden(pool_rden),
        .pool_addr(pool_addr), .pool_wdata(pool_wdata), .pool_q(pool_q),
        .pool_ready(pool_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_frame_done(rd_frame_done), .rd_frame_avail(rd_frame_avail),
        .err_overrun(err_overrun),
        .bank0_addr(bank0_addr), .bank0_wdata(bank0_wdata), .bank0_wren(bank0_wren),
        .bank0_rden(bank0_rden), .bank0_q(bank0_q),
        .bank1_addr(bank1_addr), .bank1_wdata(bank1_wdata), .bank1_wren(bank1_wren),
        .bank1_rden(bank1_rden), .bank1_q(bank1_q)
    );

    // Single-port RAM models with one-cycle read latency.
    always @(posedge clk) begin
        if (bank0_wren) mem0[bank0_addr] <= bank0_wdata;
        if (bank0_rden) bank0_q <= mem0[bank0_addr];
        if (bank1_wren) mem1[bank1_addr] <= bank1_wdata;
        if (bank1_rden) bank1_q <= mem1[bank1_addr];
    end

    typedef struct {
        logic        pd, wr, rd;
        logic [9:0]  pa;
        logic [15:0] pw;
        logic        rq;
        logic [9:0]  ra;
        logic        rfd;
        logic        e_ready, e_avail, e_gnt, e_err;
        logic [3:0]  e_strb;
        logic        e_rvalid, chk_data;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pd, wr, rd, input logic [9:0] pa, input logic [15:0] pw,
                       input logic rq, input logic [9:0] ra, input logic rfd,
                       input logic er, ea, eg, ee, input logic [3:0] es,
                       input logic ev, ec, input logic [15:0] ed);
        vec_t v;
        v.pd = pd; v.wr = wr; v.rd = rd; v.pa = pa; v.pw = pw;
        v.rq = rq; v.ra = ra; v.rfd = rfd;
        v.e_ready = er; v.e_avail = ea; v.e_gnt = eg; v.e_err = ee;
        v.e_strb = es; v.e_rvalid = ev; v.chk_data = ec; v.e_rdata = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic set_in(input logic pd, wr, rd, input logic [9:0] pa, input logic [15:0] pw,
                          input logic rq, input logic [9:0] ra, input logic rfd);
        pool_done = pd; pool_wren = wr; pool_rden = rd; pool_addr = pa; pool_wdata = pw;
        rd_req = rq; rd_addr = ra; rd_frame_done = rfd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] strb();
        return {bank1_wren, bank1_rden, bank0_wren, bank0_rden};
    endfunction

    initial begin
        int exp_addr;
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        bank0_q = '0;
        bank1_q = '0;

        // Reset state
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_ready", 0, pool_ready, 1);
        check("rst_avail", 0, rd_frame_avail, 0);
        check("rst_err", 0, err_overrun, 0);
        check("rst_gnt", 0, rd_gnt, 0);
        check("rst_valid", 0, rd_valid, 0);
        check("rst_strb", 0, strb(), 0);
        check("rst_addr", 0, {bank0_addr, bank1_addr}, 0);
        tick();
        reset = 1'b0;

        //   pd wr rd  pa     pw       rq ra  rfd  rdy avail gnt err strb  rv chk rdata
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,   1, 0, 0, 0, 4'b0000, 0, 0, 16'h0);
        add(0, 1, 0, 5,  16'hABCD, 0, 0, 0,   1, 0, 0, 0, 4'b0010, 0, 0, 16'h0);
        add(1, 0, 0, 0,  16'h0000, 0, 0, 0,   1, 0, 0, 0, 4'b0000, 0, 0, 16'h0);
        add(0, 0, 0, 0,  16'h0000, 1, 5, 0,   1, 1, 1, 0, 4'b0001, 0, 0, 16'h0);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,   1, 1, 0, 0, 4'b0000, 1, 1, 16'hABCD);
        add(0, 1, 0, 7,  16'h1234, 0, 0, 0,   1, 1, 0, 0, 4'b1000, 0, 0, 16'h0);
        add(1, 0, 0, 0,  16'h0000, 0, 0, 0,   1, 1, 0, 0, 4'b0000, 0, 0, 16'h0);
        add(0, 1, 0, 9,  16'hFFFF, 0, 0, 0,   0, 1, 0, 0, 4'b0000, 0, 0, 16'h0);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,   0, 1, 0, 1, 4'b0000, 0, 0, 16'h0);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 1,   0, 1, 0, 1, 4'b0000, 0, 0, 16'h0);
        add(0, 0, 0, 0,  16'h0000, 1, 7, 0,   !SCR, 1, 1, 1, SCR ? 4'b0110 : 4'b0100, 0, 0, 16'h0);
        add(0, 0, 0, 0,  16'h0000, 0, 0, 0,   !SCR, 1, 0, 1, SCR ? 4'b0010 : 4'b0000, 1, 1, 16'h1234);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].pd, vecs[i].wr, vecs[i].rd, vecs[i].pa, vecs[i].pw,
                   vecs[i].rq, vecs[i].ra, vecs[i].rfd);
            @(negedge clk);
            check("v_ready", i, pool_ready, vecs[i].e_ready);
            check("v_avail", i, rd_frame_avail, vecs[i].e_avail);
            check("v_gnt", i, rd_gnt, vecs[i].e_gnt);
            check("v_err", i, err_overrun, vecs[i].e_err);
            check("v_strb", i, strb(), vecs[i].e_strb);
            check("v_rvalid", i, rd_valid, vecs[i].e_rvalid);
            if (vecs[i].chk_data)
                check("v_rdata", i, rd_data, vecs[i].e_rdata);
            tick();
        end

        // Spurious rd_frame_done sets the sticky error; reset clears it; empty frame completes.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rfd_err", 0, err_overrun, 1);
        check("rfd_avail", 0, rd_frame_avail, 0);
        tick(); tick();
        @(negedge clk);
        check("err_sticky", 0, err_overrun, 1);
        do_reset();
        @(negedge clk);
        check("err_clear", 0, err_overrun, 0);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("empty_frame_avail", 0, rd_frame_avail, 1);
        check("empty_frame_ready", 0, pool_ready, 1);
        check("empty_frame_err", 0, err_overrun, 0);

        // Fill bank0, engine read-back, then overlap bank1 fill with bank0 reads.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 10'(i), 16'h1000 + 16'(i), 0, 0, 0);
            tick();
        end
        set_in(0, 0, 1, 2, 0, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("pool_q", 0, pool_q, 16'h1002);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 10'(i), 16'h5000 + 16'(i), 1, 10'(i), 0);
            @(negedge clk);
            check("ovl_gnt", i, rd_gnt, 1);
            check("ovl_strb", i, strb(), 4'b1001);
            if (i > 0) begin
                check("ovl_rvalid", i, rd_valid, 1);
                check("ovl_rdata", i, rd_data, 16'h1000 + 16'(i - 1));
            end
            tick();
        end
        // pool_done, rd_frame_done and a final read of the old bank in one cycle.
        set_in(1, 0, 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        check("sim_gnt", 0, rd_gnt, 1);
        check("sim_strb", 0, strb(), 4'b0001);
        check("sim_rdata", 0, rd_data, 16'h1003);
        check("sim_err", 0, err_overrun, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_in(0, 0, 0, 0, 0, 1, 10'(i), 0);
            else       set_in(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("b1_avail", i, rd_frame_avail, 1);
            check("b1_ready", i, pool_ready, !SCR);
            check("b1_gnt", i, rd_gnt, i < 4);
            check("b1_strb", i, strb(), {1'b0, i < 4, SCR, 1'b0});
            check("b1_rvalid", i, rd_valid, 1);
            check("b1_rdata", i, rd_data, (i == 0) ? 16'h1000 : 16'h5000 + 16'(i - 1));
            tick();
        end
        check("no_err", 0, err_overrun, 0);

`ifdef POOL_BANK_SCRUB_EN
        // Remaining scrub writes on bank0, then the bank returns to EMPTY.
        exp_addr = 5;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bank0_wren) break;
            check("scr_addr", exp_addr, bank0_addr, 10'(exp_addr));
            check("scr_wdata", exp_addr, bank0_wdata, 0);
            exp_addr++;
            tick();
        end
        check("scr_count", 0, exp_addr, 16);
        check("scr_ready", 0, pool_ready, 1);
        check("scr_zero3", 0, mem0[3], 0);
        tick();
        set_in(0, 1, 0, 5, 16'h7777, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 3, 0);
        @(negedge clk);
        check("scr_gnt3", 0, rd_gnt, 1);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 5, 0);
        @(negedge clk);
        check("scr_rd3", 0, rd_data, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("scr_rd5", 0, rd_data, 16'h7777);
        tick();
`else
        exp_addr = 0;
        set_in(0, 1, 0, 8, 16'h2222, 0, 0, 0);
        @(negedge clk);
        check("refill_strb", exp_addr, strb(), 4'b0010);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
